// File: rtl/fpnew_issue_rob_pkg.sv
// Shared FP op-field types for the FPnew issue/reorder front end.
// Encodings mirror fpnew_pkg so fields pass straight through to the FPU.
package fpnew_issue_rob_pkg;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        ROD = 3'b101,
        DYN = 3'b111
    } roundmode_e;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL,
        DIV, SQRT, SGNJ, MINMAX,
        CMP, CLASSIFY, F2F, F2I,
        I2F, CPKAB, CPKCD
    } operation_e;

    typedef enum logic [2:0] {
        FP32, FP64, FP16, FP8, FP16ALT
    } fp_format_e;

    typedef enum logic [1:0] {
        INT8, INT16, INT32, INT64
    } int_format_e;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

endpackage

// File: rtl/fpnew_issue_rob_if.sv
// FPU-side handshake bundle between the issue ROB (master) and fpnew_top (slave).
interface fpnew_issue_rob_if
    import fpnew_issue_rob_pkg::*;
#(
    parameter int unsigned Width = 32,
    parameter int unsigned TagW  = 3
) ();

    logic [3*Width-1:0] operands;
    roundmode_e         rnd_mode;
    operation_e         op;
    logic               op_mod;
    fp_format_e         src_fmt;
    fp_format_e         dst_fmt;
    int_format_e        int_fmt;
    logic               vectorial;
    logic [TagW-1:0]    tag;
    logic               in_valid;
    logic               in_ready;
    logic               flush;
    logic [Width-1:0]   result;
    status_t            status;
    logic [TagW-1:0]    out_tag;
    logic               out_valid;
    logic               out_ready;
    logic               busy;

    modport master (
        output operands, rnd_mode, op, op_mod,
        output src_fmt, dst_fmt, int_fmt, vectorial,
        output tag, in_valid, flush, out_ready,
        input  in_ready, result, status,
        input  out_tag, out_valid, busy
    );

    modport slave (
        input  operands, rnd_mode, op, op_mod,
        input  src_fmt, dst_fmt, int_fmt, vectorial,
        input  tag, in_valid, flush, out_ready,
        output in_ready, result, status,
        output out_tag, out_valid, busy
    );

endinterface

// File: rtl/fpnew_issue_rob.sv
// Issues core FP ops to FPnew tagged with a ROB slot and an epoch bit,
// and writes results back in issue order; owns sticky fflags and FPU flush.
module fpnew_issue_rob
    import fpnew_issue_rob_pkg::*;
#(
    parameter  int unsigned Width   = 32,
    parameter  int unsigned Depth   = 4,
    parameter  int unsigned RdWidth = 5,
    localparam int unsigned IdxW    = $clog2(Depth)
) (
    input  logic               clk_i,
    input  logic               rst_ni,

    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [3*Width-1:0] req_operands_i,
    input  roundmode_e         req_rnd_mode_i,
    input  operation_e         req_op_i,
    input  logic               req_op_mod_i,
    input  fp_format_e         req_src_fmt_i,
    input  fp_format_e         req_dst_fmt_i,
    input  int_format_e        req_int_fmt_i,
    input  logic               req_vectorial_i,
    input  logic [RdWidth-1:0] req_rd_i,

    output logic [3*Width-1:0] fpu_operands_o,
    output roundmode_e         fpu_rnd_mode_o,
    output operation_e         fpu_op_o,
    output logic               fpu_op_mod_o,
    output fp_format_e         fpu_src_fmt_o,
    output fp_format_e         fpu_dst_fmt_o,
    output int_format_e        fpu_int_fmt_o,
    output logic               fpu_vectorial_o,
    output logic [IdxW:0]      fpu_tag_o,
    output logic               fpu_in_valid_o,
    input  logic               fpu_in_ready_i,
    output logic               fpu_flush_o,
    input  logic [Width-1:0]   fpu_result_i,
    input  status_t            fpu_status_i,
    input  logic [IdxW:0]      fpu_tag_i,
    input  logic               fpu_out_valid_i,
    output logic               fpu_out_ready_o,
    input  logic               fpu_busy_i,

    output logic               wb_valid_o,
    input  logic               wb_ready_i,
    output logic [Width-1:0]   wb_result_o,
    output logic [RdWidth-1:0] wb_rd_o,
    output status_t            wb_status_o,

    input  logic               flush_i,
    output logic [4:0]         fflags_o,
    input  logic               fflags_clr_i,
    output logic               idle_o
);

    typedef logic [IdxW:0] tag_t;

    typedef struct packed {
        logic               alloc;
        logic               done;
        logic [RdWidth-1:0] rd;
        logic [Width-1:0]   result;
        status_t            status;
    } rob_entry_t;

    localparam logic [IdxW:0] FullCnt = (IdxW+1)'(Depth);

    rob_entry_t      ent_q [Depth];
    rob_entry_t      ent_d [Depth];
    logic [IdxW-1:0] wr_ptr_q, wr_ptr_d;
    logic [IdxW-1:0] rd_ptr_q, rd_ptr_d;
    logic [IdxW:0]   count_q, count_d;
    logic            epoch_q, epoch_d;
    logic [4:0]      fflags_q, fflags_d;

    rob_entry_t      head;
    logic            full;
    logic            issue;
    logic            retire;
    logic [IdxW-1:0] rsp_idx;
    logic            rsp_hit;

    assign fpu_operands_o  = req_operands_i;
    assign fpu_rnd_mode_o  = req_rnd_mode_i;
    assign fpu_op_o        = req_op_i;
    assign fpu_op_mod_o    = req_op_mod_i;
    assign fpu_src_fmt_o   = req_src_fmt_i;
    assign fpu_dst_fmt_o   = req_dst_fmt_i;
    assign fpu_int_fmt_o   = req_int_fmt_i;
    assign fpu_vectorial_o = req_vectorial_i;
    assign fpu_tag_o       = tag_t'({epoch_q, wr_ptr_q});
    assign fpu_flush_o     = flush_i;
    assign fpu_out_ready_o = 1'b1;

    assign full           = (count_q == FullCnt);
    assign fpu_in_valid_o = req_valid_i & ~full & ~flush_i;
    assign issue          = fpu_in_valid_o & fpu_in_ready_i;
    assign req_ready_o    = issue;

    assign head        = ent_q[rd_ptr_q];
    assign wb_valid_o  = head.alloc & head.done & ~flush_i;
    assign wb_result_o = head.result;
    assign wb_rd_o     = head.rd;
    assign wb_status_o = head.status;
    assign retire      = wb_valid_o & wb_ready_i;

    // Stale-epoch, free or already-completed slots swallow the response.
    assign rsp_idx = fpu_tag_i[IdxW-1:0];
    assign rsp_hit = fpu_out_valid_i & ~flush_i
                   & (fpu_tag_i[IdxW] == epoch_q)
                   & ent_q[rsp_idx].alloc
                   & ~ent_q[rsp_idx].done;

    assign fflags_o = fflags_q;
    assign idle_o   = (count_q == '0) & ~fpu_busy_i;

    always_comb begin
        ent_d    = ent_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        epoch_d  = epoch_q;
        if (flush_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                ent_d[i].alloc = 1'b0;
                ent_d[i].done  = 1'b0;
            end
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            epoch_d  = ~epoch_q;
        end else begin
            if (issue) begin
                ent_d[wr_ptr_q].alloc = 1'b1;
                ent_d[wr_ptr_q].done  = 1'b0;
                ent_d[wr_ptr_q].rd    = req_rd_i;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (rsp_hit) begin
                ent_d[rsp_idx].done   = 1'b1;
                ent_d[rsp_idx].result = fpu_result_i;
                ent_d[rsp_idx].status = fpu_status_i;
            end
            if (retire) begin
                ent_d[rd_ptr_q].alloc = 1'b0;
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({issue, retire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // A CSR clear racing a retire keeps only the retiring op's flags.
    always_comb begin
        fflags_d = fflags_q;
        if (fflags_clr_i) begin
            fflags_d = retire ? wb_status_o : 5'b0;
        end else if (retire) begin
            fflags_d = fflags_q | wb_status_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                ent_q[i].alloc <= 1'b0;
                ent_q[i].done  <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            epoch_q  <= 1'b0;
            fflags_q <= '0;
        end else begin
            ent_q    <= ent_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            epoch_q  <= epoch_d;
            fflags_q <= fflags_d;
        end
    end

endmodule
